rds_bit_recovery: RTL and testbench
===================================

# rds_bit_recovery

Recovers RDS data bits from the demodulated 57 kHz RDS baseband stream that `rds_wrapper` produces, and passes them to the RDS block-sync stage. Each biphase (Manchester) half-bit chip is integrated and dumped. Chip boundaries are tracked with a zero-crossing timing loop. Chips are paired into biphase symbols and differentially decoded into data bits, which leave on a one-entry AXI-Stream output register that respects back-pressure.

## Interface
- `C_S00_AXIS_TDATA_WIDTH`, 64: input bus width. The signed baseband sample is in `tdata[SAMPLE_WIDTH-1:0]`; all other bits are ignored.
- `C_M00_AXIS_TDATA_WIDTH`, 8: output bus width.
- `SAMPLE_WIDTH`, 32: signed sample width.
- `HALF_BIT_SAMPLES`, 20: samples per biphase chip (47.5 kHz / 2375 chips/s). Legal range is ≥ 4 and even.
- `clk` input, 1: single clock. All logic is on its rising edge.
- `reset` input, 1: synchronous, active-high.
- `s00_axis_tvalid` input, 1: input sample valid.
- `s00_axis_tdata` input, C_S00_AXIS_TDATA_WIDTH: baseband sample.
- `s00_axis_tlast` input, 1: ignored.
- `s00_axis_tstrb` input, C_S00_AXIS_TDATA_WIDTH/8: ignored.
- `s00_axis_tready` output, 1: `~m00_axis_tvalid | m00_axis_tready` (combinational).
- `m00_axis_tvalid` output, 1: decoded bit is available.
- `m00_axis_tready` input, 1: downstream accepts the bit.
- `m00_axis_tdata` output, C_M00_AXIS_TDATA_WIDTH: [0] data bit; [1] slip flag; upper bits are 0.
- `m00_axis_tlast` output, 1: constant 0.
- `m00_axis_tstrb` output, C_M00_AXIS_TDATA_WIDTH/8: all ones.

## Operation
- A sample is accepted when `s00_axis_tvalid & s00_axis_tready`. All state below advances only on an accepted sample.
- Accumulator:
  - width `ACC_W = SAMPLE_WIDTH + $clog2(HALF_BIT_SAMPLES) + 1`, signed, sign-extended add, cannot overflow.
  - sample counter `cnt` runs from 0 to `dump_at`.
  - on the dump sample: chip = (acc + sample ≥ 0); acc restarts at 0 and `cnt` restarts at 0.
- Timing loop:
  - `prev_sign` holds the sign of the last accepted sample; a zero sample counts as positive.
  - A crossing is a sign change at counter value c. Only the first crossing in each chip counts.
  - c = 0: nominal, `dump_at = HALF_BIT_SAMPLES-1`.
  - 1 ≤ c < H/2: the boundary is early, so the current chip is lengthened (`dump_at = H`).
  - H/2 ≤ c ≤ H-1: the boundary is late, so the current chip is shortened (`dump_at = H-2`).
  - If the crossing arrives after `cnt` has already passed H-2, the shortening is dropped.
  - At most one sample of adjustment per chip. The adjustment resets at each dump.
- Chip pairing:
  - `pair_phase` toggles on each dump. Phase 0 stores `first_chip`.
  - Phase 1 forms the symbol. If `first_chip != chip`, symbol = `first_chip` (1 = +,−; 0 = −,+).
  - If `first_chip == chip`, this is a biphase violation. The block emits nothing, keeps the current chip as the new `first_chip`, stays in phase 1 awaiting the partner chip (a one-chip slip), and sets sticky `slip`.
- Differential decode: bit = symbol ^ `prev_sym`, then `prev_sym` ← symbol.
- Output register:
  - On a valid symbol: `m00_axis_tvalid` ← 1, tdata[0] ← bit, tdata[1] ← `slip`, and `slip` is cleared.
  - The register is cleared when `tvalid & tready`.
  - While the register is full and downstream is not ready, input is stalled, so no sample or bit is lost.
- Simultaneous output handshake and new-bit load in the same cycle: the new bit wins, and `tvalid` stays 1.

## Timing
- Reset values: acc=0, cnt=0, `dump_at`=H-1, `pair_phase`=0, `first_chip`=0, `prev_sym`=0, `prev_sign`=0, `slip`=0.
- Output reset values: `m00_axis_tvalid`=0, `m00_axis_tdata`=0, `m00_axis_tlast`=0.
- Reset asserted mid-chip or mid-pair discards all partial state on the next edge.
- Latency: the bit is on `m00_axis_tdata` with `tvalid`=1 in the cycle after the accepted sample that completes the second chip.
- Throughput: 1 sample/cycle while ready, and at most one bit per 2·(H-1) samples.

## Structure
- Package `rds_pkg`: `RDS_HALF_BIT_SAMPLES`, output field indices (`RDS_BIT_IDX=0`, `RDS_SLIP_IDX=1`), and a `chip_t` typedef. The block-sync stage shares this package.
- Sub-module `rds_chip_integrator`: accumulator, counter, zero-crossing timing loop. It emits a `chip_valid`/`chip` pulse.
- The top level holds the pairing, differential decode and output register.

## Test plan
- Reset: after reset with `m00_axis_tready`=1, `s00_axis_tready`=1, `m00_axis_tvalid`=0, tdata=0.
- Aligned stream, H=20, amplitude ±1000, symbols 1,1,0,1: bits 1,0,1,1 with tdata[1]=0.
- One-chip offset (20 samples of −1000 prepended): exactly one slip; the first emitted bit has tdata[1]=1; subsequent bits decode correctly.
- 3-sample offset: dump boundary converges to the transitions within 3 chips; no errors after the first 2 bits of a 16-bit pattern.
- Back-pressure: with a bit pending, hold `m00_axis_tready`=0 for 100 cycles. `tvalid`/`tdata` stay stable, `s00_axis_tready`=0, and no samples are consumed. On release the full sequence is delivered with no loss.
- Reset at cnt=10 mid-pair: the next cycle shows all state cleared, then an aligned stream reproduces the scenario-2 output.

Source files
------------

// File: rtl/rds_pkg.sv
// Shared definitions for the RDS receive chain (bit recovery and block sync).
package rds_pkg;

  localparam int RDS_HALF_BIT_SAMPLES = 20;

  localparam int RDS_BIT_IDX  = 0;
  localparam int RDS_SLIP_IDX = 1;

  typedef logic chip_t;

  typedef enum logic {
    PAIR_FIRST  = 1'b0,
    PAIR_SECOND = 1'b1
  } pair_phase_t;

endpackage

// File: rtl/rds_chip_integrator.sv
// Integrate-and-dump of one biphase chip with a zero-crossing timing loop
// that nudges the dump point by at most one sample per chip.
module rds_chip_integrator
  import rds_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = 32,
  parameter int HALF_BIT_SAMPLES = RDS_HALF_BIT_SAMPLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  output logic                    chip_valid_o,
  output logic                    chip_o
);

  localparam int ACC_W = SAMPLE_WIDTH + $clog2(HALF_BIT_SAMPLES) + 1;
  localparam int CNT_W = $clog2(HALF_BIT_SAMPLES + 1);

  localparam logic [CNT_W-1:0] CNT_NOM   = CNT_W'(HALF_BIT_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_LONG  = CNT_W'(HALF_BIT_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(HALF_BIT_SAMPLES - 2);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF_BIT_SAMPLES / 2);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] dump_at_q;
  logic             prev_sign_q;
  logic             xing_seen_q;
  logic             sign_now;
  logic             first_xing;
  logic             late_at_limit;
  logic             dump_now;
  chip_t            chip_d;

  always_comb begin
    acc_sum       = acc_q + {{(ACC_W-SAMPLE_WIDTH){sample_i[SAMPLE_WIDTH-1]}}, sample_i};
    sign_now      = sample_i[SAMPLE_WIDTH-1];
    first_xing    = (sign_now != prev_sign_q) & ~xing_seen_q;
    // A late crossing landing exactly on H-2 ends the chip on this very sample.
    late_at_limit = first_xing & (cnt_q == CNT_SHORT);
    dump_now      = (cnt_q == dump_at_q) | late_at_limit;
    chip_d        = ~acc_sum[ACC_W-1];
  end

  assign chip_valid_o = en_i & dump_now;
  assign chip_o       = chip_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      dump_at_q   <= CNT_NOM;
      prev_sign_q <= 1'b0;
      xing_seen_q <= 1'b0;
    end else if (en_i) begin
      prev_sign_q <= sign_now;
      if (dump_now) begin
        acc_q       <= '0;
        cnt_q       <= '0;
        dump_at_q   <= CNT_NOM;
        xing_seen_q <= 1'b0;
      end else begin
        acc_q <= acc_sum;
        cnt_q <= cnt_q + CNT_W'(1);
        if (first_xing) begin
          xing_seen_q <= 1'b1;
          if (cnt_q != '0 && cnt_q < CNT_HALF) begin
            dump_at_q <= CNT_LONG;
          end else if (cnt_q >= CNT_HALF && cnt_q < CNT_SHORT) begin
            dump_at_q <= CNT_SHORT;
          end
        end
      end
    end
  end

endmodule

// File: rtl/rds_bit_recovery.sv
// RDS bit recovery: chip integration, biphase pairing with slip recovery,
// differential decode and a one-entry AXI-Stream output register.
//
// state       | meaning
// PAIR_FIRST  | waiting for the first chip of a biphase symbol
// PAIR_SECOND | first chip held, next chip completes (or slips) the symbol
module rds_bit_recovery
  import rds_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int C_M00_AXIS_TDATA_WIDTH = 8,
  parameter int SAMPLE_WIDTH           = 32,
  parameter int HALF_BIT_SAMPLES       = RDS_HALF_BIT_SAMPLES
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                                s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  output logic                                s00_axis_tready,
  output logic                                m00_axis_tvalid,
  input  logic                                m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

  pair_phase_t pair_phase_q;
  chip_t       first_chip_q;
  logic        prev_sym_q;
  logic        slip_q;
  logic        m_valid_q;
  logic        bit_q;
  logic        slip_out_q;
  logic        accept;
  logic        chip_valid;
  chip_t       chip;

  logic unused_inputs;
  assign unused_inputs = ^{s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:SAMPLE_WIDTH],
                           s00_axis_tlast, s00_axis_tstrb};

  assign s00_axis_tready = ~m_valid_q | m00_axis_tready;
  assign accept          = s00_axis_tvalid & s00_axis_tready;

  rds_chip_integrator #(
    .SAMPLE_WIDTH     (SAMPLE_WIDTH),
    .HALF_BIT_SAMPLES (HALF_BIT_SAMPLES)
  ) u_chip_integrator (
    .clk          (clk),
    .reset        (reset),
    .en_i         (accept),
    .sample_i     (s00_axis_tdata[SAMPLE_WIDTH-1:0]),
    .chip_valid_o (chip_valid),
    .chip_o       (chip)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pair_phase_q <= PAIR_FIRST;
      first_chip_q <= 1'b0;
      prev_sym_q   <= 1'b0;
      slip_q       <= 1'b0;
      m_valid_q    <= 1'b0;
      bit_q        <= 1'b0;
      slip_out_q   <= 1'b0;
    end else begin
      if (m_valid_q & m00_axis_tready) begin
        m_valid_q <= 1'b0;
      end
      if (chip_valid) begin
        case (pair_phase_q)
          PAIR_FIRST: begin
            first_chip_q <= chip;
            pair_phase_q <= PAIR_SECOND;
          end
          PAIR_SECOND: begin
            if (first_chip_q != chip) begin
              bit_q        <= first_chip_q ^ prev_sym_q;
              prev_sym_q   <= first_chip_q;
              slip_out_q   <= slip_q;
              slip_q       <= 1'b0;
              m_valid_q    <= 1'b1;
              pair_phase_q <= PAIR_FIRST;
            end else begin
              // Two equal chips cannot be one symbol: realign by one chip.
              first_chip_q <= chip;
              slip_q       <= 1'b1;
            end
          end
          default: pair_phase_q <= PAIR_FIRST;
        endcase
      end
    end
  end

  always_comb begin
    m00_axis_tdata               = '0;
    m00_axis_tdata[RDS_BIT_IDX]  = bit_q;
    m00_axis_tdata[RDS_SLIP_IDX] = slip_out_q;
  end

  assign m00_axis_tvalid = m_valid_q;
  assign m00_axis_tlast  = 1'b0;
  assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_rds_bit_recovery.sv
// Scoreboard bench for rds_bit_recovery: directed chip streams, expected bits
// queued at stimulus time and checked by an independent output monitor.
module tb_rds_bit_recovery;

  localparam int H = 20;

  logic        clk;
  logic        reset;
  logic        s00_axis_tvalid;
  logic [63:0] s00_axis_tdata;
  logic        s00_axis_tlast;
  logic [7:0]  s00_axis_tstrb;
  logic        s00_axis_tready;
  logic        m00_axis_tvalid;
  logic        m00_axis_tready;
  logic [7:0]  m00_axis_tdata;
  logic        m00_axis_tlast;
  logic [0:0]  m00_axis_tstrb;

  typedef struct packed {
    logic       care;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   smp_q[$];
  int   total = 0;
  int   bad = 0;
  int   consumed = 0;

  rds_bit_recovery dut (
    .clk             (clk),
    .reset           (reset),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tlast  (s00_axis_tlast),
    .s00_axis_tstrb  (s00_axis_tstrb),
    .s00_axis_tready (s00_axis_tready),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tready (m00_axis_tready),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tlast  (m00_axis_tlast),
    .m00_axis_tstrb  (m00_axis_tstrb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && m00_axis_tvalid && m00_axis_tready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_bit: got %0h expected none", m00_axis_tdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.care) check("bit_out", {56'h0, m00_axis_tdata}, {56'h0, e.data});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && s00_axis_tvalid && s00_axis_tready) consumed++;
  end

  task automatic add_chip(input bit c);
    repeat (H) smp_q.push_back(c ? 1000 : -1000);
  endtask

  task automatic add_symbol(input bit s);
    add_chip(s);
    add_chip(~s);
  endtask

  task automatic expect_bit(input bit b, input bit slip, input bit care);
    exp_t e;
    e.care = care;
    e.data = {6'b0, slip, b};
    exp_q.push_back(e);
  endtask

  task automatic send_all();
    int  v;
    int  n;
    bit  a;
    while (smp_q.size() > 0) begin
      v = smp_q.pop_front();
      s00_axis_tvalid = 1'b1;
      s00_axis_tdata  = {32'hA5A5_5A5A, v};
      n = 0;
      a = 1'b0;
      while (!a) begin
        @(negedge clk);
        a = s00_axis_tready;
        @(posedge clk);
        #1;
        n++;
        if (!a && n > 500) begin
          total++;
          bad++;
          $display("FAIL input_timeout: got stalled %0d cycles expected accept", n);
          smp_q.delete();
          break;
        end
      end
    end
    s00_axis_tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (40) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_s_tready"}, s00_axis_tready, 1);
    check({tag, "_m_tvalid"}, m00_axis_tvalid, 0);
    check({tag, "_m_tdata"}, m00_axis_tdata, 0);
    check({tag, "_m_tlast"}, m00_axis_tlast, 0);
    check({tag, "_m_tstrb"}, m00_axis_tstrb, 1);
  endtask

  task automatic scen_aligned();
    add_symbol(1); add_symbol(1); add_symbol(0); add_symbol(1);
    expect_bit(1, 0, 1); expect_bit(0, 0, 1); expect_bit(1, 0, 1); expect_bit(1, 0, 1);
  endtask

  initial begin
    logic [15:0] pat;
    bit          prev_s;
    bit          s;
    bit          waited;
    bit          stable_ok;
    bit          stall_ok;
    int          snap_cons;
    logic [7:0]  snap_data;

    reset           = 1'b1;
    s00_axis_tvalid = 1'b0;
    s00_axis_tdata  = '0;
    s00_axis_tlast  = 1'b0;
    s00_axis_tstrb  = '1;
    m00_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_idle("reset");

    // Aligned stream: symbols 1,1,0,1 -> bits 1,0,1,1.
    scen_aligned();
    send_all();
    drain("aligned_drain");

    // One-chip offset: leading negative chip forces one slip on the first bit.
    apply_reset();
    add_chip(0);
    add_symbol(0); add_symbol(1); add_symbol(1); add_symbol(0); add_symbol(1);
    expect_bit(0, 1, 1); expect_bit(1, 0, 1); expect_bit(0, 0, 1);
    expect_bit(1, 0, 1); expect_bit(1, 0, 1);
    send_all();
    drain("slip_drain");

    // Three-sample offset: timing loop must pull chip boundaries into line.
    apply_reset();
    pat = 16'b1011_0010_1110_0101;
    repeat (3) smp_q.push_back(-1000);
    prev_s = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s = prev_s ^ pat[i];
      add_symbol(s);
      prev_s = s;
      expect_bit(pat[i], 0, i >= 2);
    end
    send_all();
    drain("offset3_drain");

    // Back-pressure: first bit held for 100 cycles with downstream stalled.
    apply_reset();
    m00_axis_tready = 1'b0;
    scen_aligned();
    fork
      send_all();
      begin
        waited = 1'b0;
        for (int n = 0; n < 500 && !waited; n++) begin
          @(negedge clk);
          if (m00_axis_tvalid) waited = 1'b1;
        end
        check("bp_first_bit_seen", waited, 1);
        snap_data = m00_axis_tdata;
        snap_cons = consumed;
        stable_ok = 1'b1;
        stall_ok  = 1'b1;
        repeat (100) begin
          @(negedge clk);
          if (!m00_axis_tvalid || m00_axis_tdata !== snap_data) stable_ok = 1'b0;
          if (s00_axis_tready !== 1'b0) stall_ok = 1'b0;
        end
        check("bp_output_stable", stable_ok, 1);
        check("bp_held_data", snap_data, 8'h01);
        check("bp_input_stalled", stall_ok, 1);
        check("bp_no_consume", consumed, snap_cons);
        @(posedge clk);
        #1 m00_axis_tready = 1'b1;
      end
    join
    drain("bp_drain");

    // Reset mid-pair: 30 samples in, partial state must be discarded.
    apply_reset();
    add_chip(1);
    repeat (10) smp_q.push_back(-1000);
    send_all();
    apply_reset();
    check_idle("midreset");
    scen_aligned();
    send_all();
    drain("midreset_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
